// File: rtl/color_sensor_ctrl_if.sv
// Command/data handshake between the colour-sensor controller and a byte-level I2C master.
// The controller side uses the master modport, the I2C engine side uses slave.
interface color_sensor_ctrl_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_rw;
    logic [6:0] cmd_dev;
    logic [7:0] cmd_reg;
    logic [5:0] cmd_len;
    logic [7:0] tx_data;
    logic       tx_req;
    logic [7:0] rx_data;
    logic       rx_valid;
    logic       cmd_done;
    logic       cmd_nack;

    modport master (
        output cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_len, tx_data,
        input  cmd_ready, tx_req, rx_data, rx_valid, cmd_done, cmd_nack
    );

    modport slave (
        input  cmd_valid, cmd_rw, cmd_dev, cmd_reg, cmd_len, tx_data,
        output cmd_ready, tx_req, rx_data, rx_valid, cmd_done, cmd_nack
    );
endinterface

// File: rtl/color_sensor_ctrl.sv
// Colour/light sensor controller: configures the sensor, polls NUM_CH channels, retries, flags faults.
// Optional IIR averaging of published samples: define COLOR_SENSOR_CTRL_AVG_EN.
module color_sensor_ctrl #(
    parameter int unsigned NUM_CH     = 3,
    parameter int unsigned CH_BYTES   = 2,
    parameter logic [6:0]  DEV_ADDR   = 7'h44,
    parameter logic [7:0]  CFG_REG    = 8'h01,
    parameter int unsigned NUM_CFG    = 2,
    parameter logic [31:0] CFG_VALUES = 32'h0D3F_0000,
    parameter logic [7:0]  BASE_REG   = 8'h09,
    parameter int unsigned POLL_DIV   = 1000000,
    parameter int unsigned TIMEOUT    = 65535,
    parameter int unsigned MAX_RETRY  = 3,
    parameter int unsigned AVG_SHIFT  = 2
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             enable,
    input  logic                             restart,
    color_sensor_ctrl_if.master              bus,
    output logic [NUM_CH*8*CH_BYTES-1:0]     samples,
    output logic                             sample_valid,
    output logic                             configured,
    output logic                             fault,
    output logic [7:0]                       overrun_cnt,
    output logic [3:0]                       state_out
);
    localparam int unsigned CW    = 8 * CH_BYTES;
    localparam int unsigned SW    = NUM_CH * CW;
    localparam int unsigned LEN   = NUM_CH * CH_BYTES;
    localparam int unsigned CNT_W = $clog2(POLL_DIV);
    localparam int unsigned TO_W  = $clog2(TIMEOUT + 1);
    localparam int unsigned RT_W  = $clog2(MAX_RETRY + 1);
    localparam int unsigned IDX_W = $clog2(LEN + 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        CFG_REQ   = 4'd1,
        CFG_XFER  = 4'd2,
        WAIT_TICK = 4'd3,
        RD_REQ    = 4'd4,
        RD_XFER   = 4'd5,
        PUBLISH   = 4'd6,
        RETRY     = 4'd7,
        FAULT     = 4'd8
    } state_e;

    state_e            state_q, state_d;
    logic [CNT_W-1:0]  poll_cnt_q, poll_cnt_d;
    logic [TO_W-1:0]   to_cnt_q, to_cnt_d;
    logic [RT_W-1:0]   retry_cnt_q, retry_cnt_d;
    logic              retry_rd_q, retry_rd_d;
    logic              pend_q, pend_d;
    logic [1:0]        tx_idx_q, tx_idx_d;
    logic [IDX_W-1:0]  rx_idx_q, rx_idx_d;
    logic [SW-1:0]     shadow_q, shadow_d;
    logic [SW-1:0]     samples_q, samples_d;
    logic              sample_valid_q, sample_valid_d;
    logic              configured_q, configured_d;
    logic              fault_q, fault_d;
    logic [7:0]        overrun_q, overrun_d;
    logic              cmd_valid_q, cmd_valid_d;
    logic              cmd_rw_q, cmd_rw_d;
    logic [6:0]        cmd_dev_q, cmd_dev_d;
    logic [7:0]        cmd_reg_q, cmd_reg_d;
    logic [5:0]        cmd_len_q, cmd_len_d;
    logic [7:0]        tx_data_q, tx_data_d;
`ifdef COLOR_SENSOR_CTRL_AVG_EN
    logic              avg_first_q, avg_first_d;
`endif

    logic              counting, tick, accept, timeout, pend_now, rx_take;
    logic [IDX_W-1:0]  rx_idx_nx;
    logic [RT_W-1:0]   retry_inc;

    // Configuration byte i sits at bits [31-8i -: 8].
    function automatic logic [7:0] cfg_byte(input logic [1:0] idx);
        logic [31:0] w;
        w = CFG_VALUES << {idx, 3'b000};
        return w[31:24];
    endfunction

`ifdef COLOR_SENSOR_CTRL_AVG_EN
    function automatic logic [CW-1:0] iir(input logic [CW-1:0] avg, input logic [CW-1:0] raw);
        logic signed [CW:0] diff;
        diff = $signed({1'b0, raw}) - $signed({1'b0, avg});
        diff = diff >>> AVG_SHIFT;
        return avg + diff[CW-1:0];
    endfunction
`endif

    always_comb begin
        state_d        = state_q;
        poll_cnt_d     = poll_cnt_q;
        to_cnt_d       = to_cnt_q;
        retry_cnt_d    = retry_cnt_q;
        retry_rd_d     = retry_rd_q;
        pend_d         = pend_q;
        tx_idx_d       = tx_idx_q;
        rx_idx_d       = rx_idx_q;
        shadow_d       = shadow_q;
        samples_d      = samples_q;
        sample_valid_d = 1'b0;
        configured_d   = configured_q;
        fault_d        = fault_q;
        overrun_d      = overrun_q;
        cmd_valid_d    = 1'b0;
        cmd_rw_d       = cmd_rw_q;
        cmd_dev_d      = cmd_dev_q;
        cmd_reg_d      = cmd_reg_q;
        cmd_len_d      = cmd_len_q;
        tx_data_d      = 8'h00;
`ifdef COLOR_SENSOR_CTRL_AVG_EN
        avg_first_d    = avg_first_q;
`endif

        counting  = (state_q != IDLE) && (state_q != FAULT);
        tick      = counting && (poll_cnt_q == CNT_W'(POLL_DIV - 1));
        accept    = cmd_valid_q && bus.cmd_ready;
        timeout   = (to_cnt_q == TO_W'(TIMEOUT - 1));
        pend_now  = pend_q || restart;
        rx_take   = bus.rx_valid && (rx_idx_q < IDX_W'(LEN));
        rx_idx_nx = rx_take ? rx_idx_q + IDX_W'(1) : rx_idx_q;
        retry_inc = retry_cnt_q + RT_W'(1);

        // Free-running poll timebase; ticks outside WAIT_TICK are dropped and counted.
        if (!counting || tick) poll_cnt_d = '0;
        else                   poll_cnt_d = poll_cnt_q + CNT_W'(1);
        if (tick && (state_q != WAIT_TICK) && (overrun_q != 8'hFF))
            overrun_d = overrun_q + 8'd1;

        if (restart) begin
            configured_d = 1'b0;
            pend_d       = 1'b1;
        end

        case (state_q)
            IDLE: begin
                pend_d = 1'b0;
                if (enable) state_d = (configured_q && !restart) ? WAIT_TICK : CFG_REQ;
            end
            CFG_REQ: begin
                if (accept) begin
                    state_d  = CFG_XFER;
                    to_cnt_d = '0;
                end
            end
            CFG_XFER: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (bus.tx_req && (tx_idx_q != 2'(NUM_CFG - 1)))
                    tx_idx_d = tx_idx_q + 2'd1;
                if (bus.cmd_done) begin
                    to_cnt_d = '0;
                    if (!bus.cmd_nack) begin
                        configured_d = !pend_now;
                        retry_cnt_d  = '0;
`ifdef COLOR_SENSOR_CTRL_AVG_EN
                        avg_first_d  = 1'b1;
`endif
                        state_d = !enable ? IDLE : (pend_now ? CFG_REQ : WAIT_TICK);
                    end else begin
                        retry_rd_d = 1'b0;
                        state_d    = RETRY;
                    end
                end else if (timeout) begin
                    to_cnt_d   = '0;
                    retry_rd_d = 1'b0;
                    state_d    = RETRY;
                end
            end
            WAIT_TICK: begin
                if (!enable)       state_d = IDLE;
                else if (pend_now) state_d = CFG_REQ;
                else if (tick)     state_d = RD_REQ;
            end
            RD_REQ: begin
                if (accept) begin
                    state_d  = RD_XFER;
                    to_cnt_d = '0;
                    rx_idx_d = '0;
                end
            end
            RD_XFER: begin
                to_cnt_d = to_cnt_q + TO_W'(1);
                if (rx_take) begin
                    shadow_d[{rx_idx_q, 3'b000} +: 8] = bus.rx_data;
                    rx_idx_d = rx_idx_nx;
                end
                if (bus.cmd_done) begin
                    to_cnt_d = '0;
                    if (!bus.cmd_nack && (rx_idx_nx == IDX_W'(LEN))) begin
                        // Publish on the transition so samples land one cycle after cmd_done.
`ifdef COLOR_SENSOR_CTRL_AVG_EN
                        for (int k = 0; k < NUM_CH; k++)
                            samples_d[k*CW +: CW] = avg_first_q ? shadow_d[k*CW +: CW]
                                                  : iir(samples_q[k*CW +: CW], shadow_d[k*CW +: CW]);
                        avg_first_d = 1'b0;
`else
                        samples_d = shadow_d;
`endif
                        sample_valid_d = 1'b1;
                        retry_cnt_d    = '0;
                        state_d        = PUBLISH;
                    end else begin
                        retry_rd_d = 1'b1;
                        state_d    = RETRY;
                    end
                end else if (timeout) begin
                    to_cnt_d   = '0;
                    retry_rd_d = 1'b1;
                    state_d    = RETRY;
                end
            end
            PUBLISH: begin
                state_d = !enable ? IDLE : (pend_now ? CFG_REQ : WAIT_TICK);
            end
            RETRY: begin
                retry_cnt_d = retry_inc;
                if (retry_inc >= RT_W'(MAX_RETRY)) begin
                    fault_d = 1'b1;
                    state_d = FAULT;
                end else if (!enable) begin
                    state_d = IDLE;
                end else begin
                    state_d = (retry_rd_q && !pend_now) ? RD_REQ : CFG_REQ;
                end
            end
            FAULT: begin
                pend_d = 1'b0;
                if (restart) begin
                    fault_d     = 1'b0;
                    retry_cnt_d = '0;
                    state_d     = enable ? CFG_REQ : IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Entering a configuration write consumes any pending restart.
        if ((state_d == CFG_REQ) && (state_q != CFG_REQ)) begin
            pend_d   = 1'b0;
            tx_idx_d = 2'd0;
        end

        // Command fields are registered from the next state so they are stable while requested.
        if (state_d == CFG_REQ) begin
            cmd_valid_d = 1'b1;
            cmd_rw_d    = 1'b0;
            cmd_dev_d   = DEV_ADDR;
            cmd_reg_d   = CFG_REG;
            cmd_len_d   = 6'(NUM_CFG);
        end else if (state_d == RD_REQ) begin
            cmd_valid_d = 1'b1;
            cmd_rw_d    = 1'b1;
            cmd_dev_d   = DEV_ADDR;
            cmd_reg_d   = BASE_REG;
            cmd_len_d   = 6'(LEN);
        end
        if ((state_d == CFG_REQ) || (state_d == CFG_XFER))
            tx_data_d = cfg_byte(tx_idx_d);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q        <= IDLE;
            poll_cnt_q     <= '0;
            to_cnt_q       <= '0;
            retry_cnt_q    <= '0;
            retry_rd_q     <= 1'b0;
            pend_q         <= 1'b0;
            tx_idx_q       <= 2'd0;
            rx_idx_q       <= '0;
            shadow_q       <= '0;
            samples_q      <= '0;
            sample_valid_q <= 1'b0;
            configured_q   <= 1'b0;
            fault_q        <= 1'b0;
            overrun_q      <= 8'h00;
            cmd_valid_q    <= 1'b0;
            cmd_rw_q       <= 1'b0;
            cmd_dev_q      <= 7'h00;
            cmd_reg_q      <= 8'h00;
            cmd_len_q      <= 6'h00;
            tx_data_q      <= 8'h00;
`ifdef COLOR_SENSOR_CTRL_AVG_EN
            avg_first_q    <= 1'b1;
`endif
        end else begin
            state_q        <= state_d;
            poll_cnt_q     <= poll_cnt_d;
            to_cnt_q       <= to_cnt_d;
            retry_cnt_q    <= retry_cnt_d;
            retry_rd_q     <= retry_rd_d;
            pend_q         <= pend_d;
            tx_idx_q       <= tx_idx_d;
            rx_idx_q       <= rx_idx_d;
            shadow_q       <= shadow_d;
            samples_q      <= samples_d;
            sample_valid_q <= sample_valid_d;
            configured_q   <= configured_d;
            fault_q        <= fault_d;
            overrun_q      <= overrun_d;
            cmd_valid_q    <= cmd_valid_d;
            cmd_rw_q       <= cmd_rw_d;
            cmd_dev_q      <= cmd_dev_d;
            cmd_reg_q      <= cmd_reg_d;
            cmd_len_q      <= cmd_len_d;
            tx_data_q      <= tx_data_d;
`ifdef COLOR_SENSOR_CTRL_AVG_EN
            avg_first_q    <= avg_first_d;
`endif
        end
    end

    assign bus.cmd_valid = cmd_valid_q;
    assign bus.cmd_rw    = cmd_rw_q;
    assign bus.cmd_dev   = cmd_dev_q;
    assign bus.cmd_reg   = cmd_reg_q;
    assign bus.cmd_len   = cmd_len_q;
    assign bus.tx_data   = tx_data_q;
    assign samples       = samples_q;
    assign sample_valid  = sample_valid_q;
    assign configured    = configured_q;
    assign fault         = fault_q;
    assign overrun_cnt   = overrun_q;
    assign state_out     = state_q;
endmodule

// File: doc/color_sensor_ctrl.md
Name: color_sensor_ctrl

Overview:
- Parametrised successor of the single-sensor RGB front end. Configures an I2C colour/light sensor, then polls it periodically.
- Reads NUM_CH channels of CH_BYTES each and publishes a packed sample word with a valid pulse.
- Retries on NACK or timeout, with a sticky fault after repeated failures.
- Drives a byte-level I2C master through a command handshake; it contains no SCL/SDA logic.

Parameters:
- NUM_CH, 3, channels read per poll (1..8).
- CH_BYTES, 2, bytes per channel (1 or 2), little-endian on the bus.
- DEV_ADDR, 7'h44, 7-bit sensor address.
- CFG_REG, 8'h01, first configuration register.
- NUM_CFG, 2, configuration bytes written (1..4).
- CFG_VALUES, 32'h0D3F_0000, configuration bytes, MSB-first; byte i is bits [31-8i -: 8].
- BASE_REG, 8'h09, first data register; reads auto-increment.
- POLL_DIV, 1000000, clock cycles between poll starts (>= 16).
- TIMEOUT, 65535, cycles allowed from command accept to cmd_done.
- MAX_RETRY, 3, consecutive failed attempts tolerated before fault.
- AVG_SHIFT, 2, IIR weight (only used with the optional feature).

Ports:
- clock, input, 1, system clock.
- reset_n, input, 1, asynchronous active-low reset.
- enable, input, 1, level; high permits configuration and polling.
- restart, input, 1, pulse; clears fault and re-runs configuration.
- cmd_valid, output, 1, transaction request to the I2C master.
- cmd_ready, input, 1, master accepts the request when both cmd_valid and cmd_ready are high.
- cmd_rw, output, 1, 0 = write, 1 = read.
- cmd_dev, output, 7, device address (always DEV_ADDR).
- cmd_reg, output, 8, register pointer.
- cmd_len, output, 6, number of data bytes.
- tx_data, output, 8, current write byte.
- tx_req, input, 1, pulse; master consumed tx_data, so advance to the next byte.
- rx_data, input, 8, read byte.
- rx_valid, input, 1, pulse; rx_data is valid.
- cmd_done, input, 1, pulse; transaction finished.
- cmd_nack, input, 1, qualified by cmd_done; 1 = failure.
- samples, output, NUM_CH*8*CH_BYTES, channel k at [k*8*CH_BYTES +: 8*CH_BYTES].
- sample_valid, output, 1, one-cycle pulse on each update of samples.
- configured, output, 1, high after a successful configuration write.
- fault, output, 1, sticky failure flag.
- overrun_cnt, output, 8, saturating count of missed poll ticks.
- state_out, output, 4, current FSM state encoding, for debug.

Behaviour:
Reset (reset_n low):
- All outputs are 0.
- FSM goes to IDLE.
- Poll counter and retry counter are cleared.

FSM states and transitions:
- IDLE: wait for enable; then go to CFG_REQ.
- CFG_REQ: cmd_valid=1, cmd_rw=0, cmd_reg=CFG_REG, cmd_len=NUM_CFG. Hold all cmd_* stable until the handshake completes, then go to CFG_XFER.
- CFG_XFER:
  - tx_data = CFG_VALUES byte 0; each tx_req advances to the next byte.
  - tx_req beyond NUM_CFG bytes keeps the last byte.
  - cmd_done with nack=0: configured<=1, retry counter cleared, go to WAIT_TICK.
  - cmd_done with nack=1, or timeout: go to RETRY.
- WAIT_TICK:
  - The poll counter counts continuously in every state except IDLE and FAULT.
  - When the counter reaches POLL_DIV-1 (a tick), it wraps to 0 and the FSM goes to RD_REQ.
- RD_REQ: cmd_rw=1, cmd_reg=BASE_REG, cmd_len=NUM_CH*CH_BYTES. After the handshake, go to RD_XFER.
- RD_XFER:
  - Each rx_valid writes rx_data into a shadow buffer at byte index i, then i increments.
  - Bytes arriving with i >= cmd_len are ignored.
  - cmd_done with nack=0 and i == cmd_len: go to PUBLISH.
  - cmd_done with nack=1, a short byte count, or timeout: go to RETRY.
- PUBLISH:
  - samples <= shadow buffer; sample_valid pulses in the same cycle samples updates.
  - Retry counter cleared.
  - Go to WAIT_TICK, or IDLE if enable is low.
- RETRY:
  - Increment the retry counter.
  - If it reaches MAX_RETRY: fault<=1, go to FAULT.
  - Otherwise re-issue the failed transaction type (configuration writes retry as CFG_REQ, reads retry as RD_REQ) on the next cycle.
- FAULT:
  - Held until restart or reset.
  - restart: fault<=0, configured<=0, go to CFG_REQ if enable is high, else IDLE.

Timing:
- Latency: sample_valid asserts exactly 1 cycle after the successful read's cmd_done.
- The timeout counter starts on handshake acceptance and is cleared on cmd_done.

Boundary conditions:
- Tick while not in WAIT_TICK: overrun_cnt increments, saturating at 255. The poll is not queued.
- enable falls mid-transaction: finish the current transaction (never drop cmd_valid before acceptance), then go to IDLE. samples and configured are kept.
- enable rises while configured=1: skip configuration and go to WAIT_TICK.
- restart in a non-FAULT state: configured<=0 and configuration is re-run after the current transaction completes.
- cmd_done and a timeout in the same cycle: cmd_done takes priority.
- Retry counter is cleared on any success.
- samples is unchanged on any failure.

Optional Feature:
Macro: COLOR_SENSOR_CTRL_AVG_EN.
- Defined:
  - Each channel holds an IIR average of the same width as the raw channel word: avg <= avg + ((new - avg) >>> AVG_SHIFT).
  - The difference is computed signed, one bit wider than the channel word.
  - The first sample after configuration loads avg directly.
  - samples carries the averages.
- Undefined: samples carries the raw values; no averaging logic is synthesised.

Test Plan:
- Reset, enable=1, sensor model ACKs everything -> write to reg 8'h01, len 2, bytes 8'h0D then 8'h3F; configured=1; first read at reg 8'h09, len 6 after POLL_DIV cycles.
- Read returns 34 12 78 56 BC 9A -> samples = 48'h9ABC_5678_1234, sample_valid high 1 cycle, 1 cycle after cmd_done.
- Read NACK twice, then ACK with data -> two re-issued reads, fault=0, samples updated once.
- Configuration NACK 3 times (MAX_RETRY=3) -> fault=1, no further cmd_valid; restart pulse -> fault=0 and a new configuration write is issued.
- Master stalls done for 200000 cycles with POLL_DIV=100000 and TIMEOUT large -> overrun_cnt=2, samples unchanged until that read completes.
- AVG_EN built, AVG_SHIFT=2, channel 0 reads 100 then 200 -> samples[15:0] = 100, then 125.
